// File: rtl/tppe_pkg.sv
// Shared TPPE package.
// Holds the default Fibre A geometry, the lane-index type for the default
// lane count, and the tag FIFO occupancy states used by the Fibre A arbiter.
package tppe_pkg;

   localparam int NUM_REQ_DEF    = 4;
   localparam int TIMESTEPS_DEF  = 4;
   localparam int ADDR_WIDTH_DEF = 8;

   localparam int LANE_IDX_W = $clog2(NUM_REQ_DEF);
   typedef logic [LANE_IDX_W-1:0] lane_idx_t;

   typedef enum logic [1:0] {
      FIFO_EMPTY   = 2'd0,
      FIFO_PARTIAL = 2'd1,
      FIFO_FULL    = 2'd2
   } fifo_state_t;

endpackage

// File: rtl/fibre_a_arbiter_if.sv
// Fibre A arbiter bus: lane request/response signals, the shared memory read
// port, and the sticky error flags.
//   slave  : arbiter side (consumes lane requests and memory data)
//   master : lane/memory side (drives requests and memory responses)
interface fibre_a_arbiter_if
   import tppe_pkg::*;
#(
   parameter int NUM_REQ    = NUM_REQ_DEF,
   parameter int TIMESTEPS  = TIMESTEPS_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

   logic [NUM_REQ-1:0]            req_read_en;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [TIMESTEPS-1:0]          req_data;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_busy;
   logic [ADDR_WIDTH-1:0]         mem_addr;
   logic                          mem_read_en;
   logic [TIMESTEPS-1:0]          mem_data;
   logic                          mem_valid;
   logic                          err_overrun;
   logic                          err_spurious;

   modport slave (
      input  req_read_en, req_addr, mem_data, mem_valid,
      output req_data, req_valid, req_busy, mem_addr, mem_read_en,
             err_overrun, err_spurious
   );

   modport master (
      output req_read_en, req_addr, mem_data, mem_valid,
      input  req_data, req_valid, req_busy, mem_addr, mem_read_en,
             err_overrun, err_spurious
   );

endinterface

// File: rtl/fibre_a_tag_fifo.sv
// Synchronous FIFO of lane indices recording the issue order of in-flight
// Fibre A reads. Occupancy state (EMPTY/PARTIAL/FULL) is derived from count.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push, push_data  write a lane index (ignored when full)
//   pop              discard the head entry (ignored when empty)
//   pop_data         head entry
//   full, empty      occupancy flags
module fibre_a_tag_fifo
   import tppe_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   fifo_state_t      state;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      state = FIFO_PARTIAL;
      if (count == '0)
         state = FIFO_EMPTY;
      else if (count == CNT_W'(DEPTH))
         state = FIFO_FULL;
   end

   assign full     = (state == FIFO_FULL);
   assign empty    = (state == FIFO_EMPTY);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = store[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fibre_a_arbiter.sv
// Round-robin arbiter sharing one Fibre A memory read port between NUM_REQ
// accumulator-correction lanes. Requests are latched per lane, reads are
// issued one per cycle in round-robin order, in-flight reads are tracked by
// a tag FIFO and each returned word is routed to the issuing lane.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    fibre_a_arbiter_if.slave (lane requests/responses, memory port,
//          sticky err_overrun / err_spurious)
//   stall_cycles, grant_count  saturating statistics counters, present only
//          when FIBRE_A_ARB_STATS_EN is defined
module fibre_a_arbiter
   import tppe_pkg::*;
#(
   parameter int NUM_REQ         = NUM_REQ_DEF,
   parameter int TIMESTEPS       = TIMESTEPS_DEF,
   parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   fibre_a_arbiter_if.slave   bus
`ifdef FIBRE_A_ARB_STATS_EN
   ,
   output logic [15:0]        stall_cycles,
   output logic [15:0]        grant_count
`endif
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]    pending, inflight, busy, accept, cand;
   logic [NUM_REQ-1:0]    grant_oh, pop_oh, resp_oh;
   logic [ADDR_WIDTH-1:0] addr_lat  [NUM_REQ];
   logic [ADDR_WIDTH-1:0] lane_addr [NUM_REQ];
   logic [ADDR_WIDTH-1:0] grant_addr;
   logic [IDX_W-1:0]      last_grant, grant_idx, tag_head;
   logic                  grant_vld, any_cand;
   logic                  fifo_full, fifo_empty, pop, spurious;
   int                    idx;

   assign busy   = pending | inflight;
   // A request from a busy lane is dropped; it neither latches nor competes.
   assign accept = bus.req_read_en & ~busy;
   assign cand   = pending | accept;
   assign any_cand = |cand;
   assign pop      = bus.mem_valid & ~fifo_empty;
   assign spurious = bus.mem_valid & fifo_empty;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         lane_addr[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // Round-robin search starting one past the previous winner.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!grant_vld && cand[idx]) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'(idx);
         end
      end
      grant_vld = grant_vld & ~fifo_full;
   end

   always_comb begin
      grant_oh = '0;
      pop_oh   = '0;
      if (grant_vld) grant_oh[grant_idx] = 1'b1;
      if (pop)       pop_oh[tag_head]    = 1'b1;
      resp_oh = pop_oh;
      // A lane granted straight from its request pulse has no latched address yet.
      grant_addr = pending[grant_idx] ? addr_lat[grant_idx] : lane_addr[grant_idx];
   end

   fibre_a_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (IDX_W)
   ) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (grant_vld),
      .push_data (grant_idx),
      .pop       (pop),
      .pop_data  (tag_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.req_busy = busy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending          <= '0;
         inflight         <= '0;
         last_grant       <= IDX_W'(NUM_REQ - 1);
         bus.mem_read_en  <= 1'b0;
         bus.mem_addr     <= '0;
         bus.req_valid    <= '0;
         bus.req_data     <= '0;
         bus.err_overrun  <= 1'b0;
         bus.err_spurious <= 1'b0;
      end else begin
         pending         <= (pending | accept) & ~grant_oh;
         inflight        <= (inflight & ~pop_oh) | grant_oh;
         bus.mem_read_en <= grant_vld;
         bus.req_valid   <= resp_oh;
         if (grant_vld) begin
            last_grant   <= grant_idx;
            bus.mem_addr <= grant_addr;
         end
         if (pop) bus.req_data <= bus.mem_data;
         if (|(bus.req_read_en & busy)) bus.err_overrun  <= 1'b1;
         if (spurious)                  bus.err_spurious <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++)
         if (accept[i]) addr_lat[i] <= lane_addr[i];
   end

`ifdef FIBRE_A_ARB_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         grant_count  <= '0;
      end else begin
         if (any_cand && fifo_full) stall_cycles <= sat_inc(stall_cycles);
         if (grant_vld)             grant_count  <= sat_inc(grant_count);
      end
   end
`else
   logic unused_any_cand;
   assign unused_any_cand = any_cand;
`endif

endmodule

// File: tb/tb_fibre_a_arbiter.sv
// Directed bench for fibre_a_arbiter (NUM_REQ=4, TIMESTEPS=4, ADDR_WIDTH=8,
// MAX_OUTSTANDING=2). Inputs change 1 time unit after each rising edge and
// outputs are sampled at that same point.
module tb_fibre_a_arbiter;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   fibre_a_arbiter_if #(.NUM_REQ(4), .TIMESTEPS(4), .ADDR_WIDTH(8)) bus ();

`ifdef FIBRE_A_ARB_STATS_EN
   logic [15:0] stall_cycles, grant_count;
`endif

   fibre_a_arbiter #(
      .NUM_REQ(4), .TIMESTEPS(4), .ADDR_WIDTH(8), .MAX_OUTSTANDING(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef FIBRE_A_ARB_STATS_EN
      ,
      .stall_cycles (stall_cycles),
      .grant_count  (grant_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_en"},    32'(bus.mem_read_en),  32'h0);
      chk({tag, "_addr"},  32'(bus.mem_addr),     32'h0);
      chk({tag, "_rv"},    32'(bus.req_valid),    32'h0);
      chk({tag, "_data"},  32'(bus.req_data),     32'h0);
      chk({tag, "_busy"},  32'(bus.req_busy),     32'h0);
      chk({tag, "_ovr"},   32'(bus.err_overrun),  32'h0);
      chk({tag, "_spur"},  32'(bus.err_spurious), 32'h0);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.req_read_en = '0;
      bus.req_addr    = '0;
      bus.mem_data    = '0;
      bus.mem_valid   = 1'b0;
      tick();
      tick();
      chk_reset_vals("rst");
      rst_n = 1'b1;

      // Single request from lane 2
      bus.req_read_en         = 4'b0100;
      bus.req_addr[16 +: 8]   = 8'h15;
      tick();
      bus.req_read_en = '0;
      chk("t1_en",   32'(bus.mem_read_en), 32'h1);
      chk("t1_addr", 32'(bus.mem_addr),    32'h15);
      chk("t1_busy", 32'(bus.req_busy),    32'h4);
      tick();
      chk("t1_en_off", 32'(bus.mem_read_en), 32'h0);
      bus.mem_valid = 1'b1;
      bus.mem_data  = 4'b1011;
      tick();
      bus.mem_valid = 1'b0;
      chk("t1_rv",   32'(bus.req_valid), 32'h4);
      chk("t1_data", 32'(bus.req_data),  32'hB);
      chk("t1_busy_clr", 32'(bus.req_busy), 32'h0);
      tick();
      chk("t1_rv_pulse", 32'(bus.req_valid), 32'h0);

      // Contention from reset: all four lanes at once, zero-latency memory
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.req_read_en = 4'b1111;
      bus.req_addr    = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.req_read_en = '0;
         chk("t2_en",   32'(bus.mem_read_en), 32'h1);
         chk("t2_addr", 32'(bus.mem_addr),    32'h10 + 32'(i));
         if (i > 0) begin
            chk("t2_rv",   32'(bus.req_valid), 32'(1) << (i - 1));
            chk("t2_data", 32'(bus.req_data),  32'(i));
         end
         bus.mem_valid = 1'b1;
         bus.mem_data  = 4'(i + 1);
      end
      tick();
      bus.mem_valid = 1'b0;
      chk("t2_rv_last",   32'(bus.req_valid),   32'h8);
      chk("t2_data_last", 32'(bus.req_data),    32'h4);
      chk("t2_en_off",    32'(bus.mem_read_en), 32'h0);
      chk("t2_busy",      32'(bus.req_busy),    32'h0);

      // Fairness: lane 1 granted, then lanes 0 and 3 together -> 3 first
      bus.req_read_en       = 4'b0010;
      bus.req_addr[8 +: 8]  = 8'h21;
      tick();
      bus.req_read_en = '0;
      chk("t3_addr1", 32'(bus.mem_addr), 32'h21);
      bus.mem_valid = 1'b1;
      bus.mem_data  = 4'h5;
      tick();
      bus.mem_valid = 1'b0;
      chk("t3_rv1", 32'(bus.req_valid), 32'h2);
      bus.req_read_en       = 4'b1001;
      bus.req_addr[0 +: 8]  = 8'h30;
      bus.req_addr[24 +: 8] = 8'h33;
      tick();
      bus.req_read_en = '0;
      chk("t3_first_en",   32'(bus.mem_read_en), 32'h1);
      chk("t3_first_addr", 32'(bus.mem_addr),    32'h33);
      bus.mem_valid = 1'b1;
      bus.mem_data  = 4'h6;
      tick();
      chk("t3_second_addr", 32'(bus.mem_addr),  32'h30);
      chk("t3_rv3",         32'(bus.req_valid), 32'h8);
      bus.mem_data = 4'h7;
      tick();
      bus.mem_valid = 1'b0;
      chk("t3_rv0",   32'(bus.req_valid), 32'h1);
      chk("t3_data0", 32'(bus.req_data),  32'h7);

      // Backpressure: three lanes, memory silent, only two strobes
      bus.req_read_en       = 4'b1110;
      bus.req_addr[8 +: 8]  = 8'h41;
      bus.req_addr[16 +: 8] = 8'h42;
      bus.req_addr[24 +: 8] = 8'h43;
      tick();
      bus.req_read_en = '0;
      chk("t4_en1",   32'(bus.mem_read_en), 32'h1);
      chk("t4_addr1", 32'(bus.mem_addr),    32'h41);
      tick();
      chk("t4_en2",   32'(bus.mem_read_en), 32'h1);
      chk("t4_addr2", 32'(bus.mem_addr),    32'h42);
      tick();
      chk("t4_stall_en",   32'(bus.mem_read_en), 32'h0);
      chk("t4_stall_busy", 32'(bus.req_busy),    32'hE);
      tick();
      chk("t4_stall_en2",  32'(bus.mem_read_en), 32'h0);
      bus.mem_valid = 1'b1;
      bus.mem_data  = 4'h9;
      tick();
      bus.mem_valid = 1'b0;
      chk("t4_rv1",      32'(bus.req_valid),   32'h2);
      chk("t4_en_still", 32'(bus.mem_read_en), 32'h0);
      tick();
      chk("t4_en3",   32'(bus.mem_read_en), 32'h1);
      chk("t4_addr3", 32'(bus.mem_addr),    32'h43);
      bus.mem_valid = 1'b1;
      tick();
      chk("t4_rv2", 32'(bus.req_valid), 32'h4);
      tick();
      bus.mem_valid = 1'b0;
      chk("t4_rv3",  32'(bus.req_valid),    32'h8);
      tick();
      chk("t4_busy", 32'(bus.req_busy),     32'h0);
      chk("t4_ovr",  32'(bus.err_overrun),  32'h0);
      chk("t4_spur", 32'(bus.err_spurious), 32'h0);

      // Overrun: lane 0 pending behind a full FIFO pulses again
      bus.req_read_en       = 4'b0110;
      bus.req_addr[8 +: 8]  = 8'h61;
      bus.req_addr[16 +: 8] = 8'h62;
      tick();
      chk("t5_addr61", 32'(bus.mem_addr), 32'h61);
      bus.req_read_en      = 4'b0001;
      bus.req_addr[0 +: 8] = 8'h50;
      tick();
      chk("t5_addr62", 32'(bus.mem_addr), 32'h62);
      bus.req_addr[0 +: 8] = 8'h5F;
      tick();
      bus.req_read_en = '0;
      chk("t5_ovr",    32'(bus.err_overrun), 32'h1);
      chk("t5_en_off", 32'(bus.mem_read_en), 32'h0);
      chk("t5_busy",   32'(bus.req_busy),    32'h7);
      bus.mem_valid = 1'b1;
      bus.mem_data  = 4'h1;
      tick();
      bus.mem_valid = 1'b0;
      chk("t5_rv1", 32'(bus.req_valid), 32'h2);
      tick();
      chk("t5_en0",   32'(bus.mem_read_en), 32'h1);
      chk("t5_addr0", 32'(bus.mem_addr),    32'h50);
      bus.mem_valid = 1'b1;
      bus.mem_data  = 4'h2;
      tick();
      chk("t5_rv2", 32'(bus.req_valid), 32'h4);
      bus.mem_data = 4'hC;
      tick();
      bus.mem_valid = 1'b0;
      chk("t5_rv0",   32'(bus.req_valid),    32'h1);
      chk("t5_data0", 32'(bus.req_data),     32'hC);
      chk("t5_busy0", 32'(bus.req_busy),     32'h0);
      chk("t5_spur0", 32'(bus.err_spurious), 32'h0);

      // Spurious response with nothing outstanding
      bus.mem_valid = 1'b1;
      bus.mem_data  = 4'hF;
      tick();
      bus.mem_valid = 1'b0;
      chk("t5_spur",     32'(bus.err_spurious), 32'h1);
      chk("t5_spur_rv",  32'(bus.req_valid),    32'h0);
      chk("t5_spur_dat", 32'(bus.req_data),     32'hC);

      // Reset with two reads outstanding
      bus.req_read_en      = 4'b0011;
      bus.req_addr[0 +: 8] = 8'h70;
      bus.req_addr[8 +: 8] = 8'h71;
      tick();
      bus.req_read_en = '0;
      chk("t6_addr1", 32'(bus.mem_addr), 32'h71);
      tick();
      chk("t6_addr0", 32'(bus.mem_addr),    32'h70);
      chk("t6_busy",  32'(bus.req_busy),    32'h3);
      chk("t6_ovr",   32'(bus.err_overrun), 32'h1);
      rst_n = 1'b0;
      tick();
      chk_reset_vals("t6_rst");
      rst_n         = 1'b1;
      bus.mem_valid = 1'b1;
      bus.mem_data  = 4'h3;
      tick();
      bus.mem_valid = 1'b0;
      chk("t6_spur", 32'(bus.err_spurious), 32'h1);
      chk("t6_rv",   32'(bus.req_valid),    32'h0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
